// File: rtl/register_file_bank.sv
// register_file_bank
//   Multi-register bank with one write port and two read ports (A/B).
//   Optional features: register 0 hardwired to zero, write-to-read bypass,
//   and either combinational or one-cycle registered reads.
//
// Ports
//   Clock        : single clock, rising-edge active
//   Reset        : synchronous active-high clear (acts regardless of upd)
//   ClockEnable  : update qualifier (upd = ClockEnable & Tick)
//   Tick         : update qualifier
//   pre          : synchronous preset of all registers to all-ones
//   WriteEnable  : write request
//   WriteAddr    : write index
//   WriteData    : write value
//   ReadAddrA/B  : read indices for ports A/B
//   cs           : when high, DataA/DataB float (all-Z)
//   DataA/DataB  : read data

module register_file_bank #(
  parameter int NrOfBits    = 32,
  parameter int NrOfRegs    = 32,
  parameter int AddrBits    = 5,
  parameter int ZeroReg     = 1,
  parameter int Bypass      = 1,
  parameter int ReadLatency = 0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                pre,
  input  logic                WriteEnable,
  input  logic [AddrBits-1:0] WriteAddr,
  input  logic [NrOfBits-1:0] WriteData,
  input  logic [AddrBits-1:0] ReadAddrA,
  input  logic [AddrBits-1:0] ReadAddrB,
  input  logic                cs,
  output logic [NrOfBits-1:0] DataA,
  output logic [NrOfBits-1:0] DataB
);

  // Register count widened by one bit so NrOfRegs == 2**AddrBits still fits.
  localparam logic [AddrBits:0] NumRegsW = (AddrBits+1)'(NrOfRegs);

  // An address is "live" when it names a real, writable/readable register.
  function automatic logic addr_live(input logic [AddrBits-1:0] a);
    return ({1'b0, a} < NumRegsW) && !((ZeroReg != 0) && (a == '0));
  endfunction

  logic upd;
  logic wr_valid;

  assign upd      = ClockEnable & Tick;
  assign wr_valid = upd & WriteEnable & ~pre & addr_live(WriteAddr);

  // Stored register values gathered for the read muxes.
  logic [NrOfBits-1:0] rd_bank [NrOfRegs];

  genvar gi;
  generate
    for (gi = 0; gi < NrOfRegs; gi++) begin : g_reg
      localparam bit Hardwired = (ZeroReg != 0) && (gi == 0);

      logic [NrOfBits-1:0] reg_d;
      logic [NrOfBits-1:0] reg_q;

      always_comb begin
        reg_d = reg_q;
        if (upd && pre) begin
          reg_d = Hardwired ? '0 : '1;
        end else if (wr_valid && (WriteAddr == AddrBits'(gi))) begin
          reg_d = WriteData;
        end
      end

      always_ff @(posedge Clock) begin
        if (Reset) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign rd_bank[gi] = reg_q;
    end
  endgenerate

  logic [AddrBits-1:0] rd_addr  [2];
  logic [NrOfBits-1:0] port_val [2];

  assign rd_addr[0] = ReadAddrA;
  assign rd_addr[1] = ReadAddrB;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [NrOfBits-1:0] stored;
      logic [NrOfBits-1:0] comb_val;
      logic                live;
      logic                byp_hit;

      // Out-of-range addresses match no entry and read back as zero.
      always_comb begin
        stored = '0;
        for (int i = 0; i < NrOfRegs; i++) begin
          if (rd_addr[gi] == AddrBits'(i)) begin
            stored = rd_bank[i];
          end
        end
      end

      assign live     = addr_live(rd_addr[gi]);
      // wr_valid already excludes discarded writes, so a bypass never
      // forwards data that would not actually land in the bank.
      assign byp_hit  = (Bypass != 0) && wr_valid && (WriteAddr == rd_addr[gi]);
      assign comb_val = byp_hit ? WriteData : (live ? stored : '0);

      if (ReadLatency == 1) begin : g_lat1
        logic [NrOfBits-1:0] out_d;
        logic [NrOfBits-1:0] out_q;

        always_comb begin
          out_d = out_q;
          if (upd) begin
            // Under preset the captured value is the post-preset content.
            if (pre) begin
              out_d = live ? '1 : '0;
            end else begin
              out_d = comb_val;
            end
          end
        end

        always_ff @(posedge Clock) begin
          if (Reset) begin
            out_q <= '0;
          end else begin
            out_q <= out_d;
          end
        end

        assign port_val[gi] = out_q;
      end else begin : g_lat0
        assign port_val[gi] = comb_val;
      end
    end
  endgenerate

  assign DataA = cs ? {NrOfBits{1'bz}} : port_val[0];
  assign DataB = cs ? {NrOfBits{1'bz}} : port_val[1];

endmodule

// File: tb/tb_register_file_bank.sv
// tb_register_file_bank
//   Drives three bank configurations in lock-step from the same stimulus:
//     d0: defaults (32 regs, zero reg, bypass, combinational reads)
//     d1: 24 regs, zero reg, bypass, registered reads
//     d2: 32 regs, no zero reg, no bypass, registered reads
//   A behavioural model produces expected read data; values are queued when
//   stimulus is applied and compared when each DUT presents its output.

module tb_register_file_bank;

  logic        Clock;
  logic        Reset;
  logic        ClockEnable;
  logic        Tick;
  logic        pre;
  logic        WriteEnable;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic [4:0]  ReadAddrA;
  logic [4:0]  ReadAddrB;
  logic        cs;
  wire  [31:0] da0, db0, da1, db1, da2, db2;

  register_file_bank u_d0 (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .pre(pre), .WriteEnable(WriteEnable), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB),
    .cs(cs), .DataA(da0), .DataB(db0)
  );

  register_file_bank #(.NrOfRegs(24), .ZeroReg(1), .Bypass(1), .ReadLatency(1)) u_d1 (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .pre(pre), .WriteEnable(WriteEnable), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB),
    .cs(cs), .DataA(da1), .DataB(db1)
  );

  register_file_bank #(.NrOfRegs(32), .ZeroReg(0), .Bypass(0), .ReadLatency(1)) u_d2 (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .pre(pre), .WriteEnable(WriteEnable), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB),
    .cs(cs), .DataA(da2), .DataB(db2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int cfg_n   [3] = '{32, 24, 32};
  bit cfg_zr  [3] = '{1'b1, 1'b1, 1'b0};
  bit cfg_byp [3] = '{1'b1, 1'b1, 1'b0};

  logic [31:0] m     [3][32];
  logic [31:0] out_a [3];
  logic [31:0] out_b [3];

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];

  int n_checks = 0;
  int n_errors = 0;
  int txn      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (txn %0d)", tag, got, exp, txn);
    end
  endtask

  function automatic bit live(input int c, input logic [4:0] a);
    return (int'(a) < cfg_n[c]) && !(cfg_zr[c] && (a == 5'd0));
  endfunction

  function automatic logic [31:0] model_read(input int c, input logic [4:0] a,
                                            input bit wv, input logic [4:0] wa,
                                            input logic [31:0] wd);
    if (cfg_byp[c] && wv && (wa == a)) return wd;
    if (!live(c, a)) return 32'd0;
    return m[c][a];
  endfunction

  function automatic logic [31:0] mask_cs(input bit c, input logic [31:0] v);
    return c ? {32{1'bz}} : v;
  endfunction

  task automatic step(input bit rst, input bit ce, input bit tk, input bit pr,
                      input bit we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb, input bit c);
    logic [31:0] ca [3];
    logic [31:0] cb [3];
    bit          wv [3];
    bit          upd;

    Reset = rst; ClockEnable = ce; Tick = tk; pre = pr;
    WriteEnable = we; WriteAddr = wa; WriteData = wd;
    ReadAddrA = ra; ReadAddrB = rb; cs = c;
    upd = ce & tk;

    for (int k = 0; k < 3; k++) begin
      wv[k] = upd && we && !pr && live(k, wa);
      ca[k] = model_read(k, ra, wv[k], wa, wd);
      cb[k] = model_read(k, rb, wv[k], wa, wd);
    end

    // Combinational port: expected in this same cycle.
    q0.push_back(mask_cs(c, ca[0]));
    q0.push_back(mask_cs(c, cb[0]));

    // Advance the model across the edge.
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) m[k][i] = 32'd0;
        out_a[k] = 32'd0;
        out_b[k] = 32'd0;
      end else if (upd) begin
        if (pr) begin
          for (int i = 0; i < cfg_n[k]; i++)
            m[k][i] = (cfg_zr[k] && i == 0) ? 32'd0 : 32'hFFFF_FFFF;
          out_a[k] = live(k, ra) ? 32'hFFFF_FFFF : 32'd0;
          out_b[k] = live(k, rb) ? 32'hFFFF_FFFF : 32'd0;
        end else begin
          out_a[k] = ca[k];
          out_b[k] = cb[k];
          if (wv[k]) m[k][wa] = wd;
        end
      end
    end

    // Registered ports: expected after the edge.
    q1.push_back(mask_cs(c, out_a[1]));
    q1.push_back(mask_cs(c, out_b[1]));
    q2.push_back(mask_cs(c, out_a[2]));
    q2.push_back(mask_cs(c, out_b[2]));

    #1;
    check_eq("d0.A", da0, q0.pop_front());
    check_eq("d0.B", db0, q0.pop_front());
    @(posedge Clock);
    #1;
    check_eq("d1.A", da1, q1.pop_front());
    check_eq("d1.B", db1, q1.pop_front());
    check_eq("d2.A", da2, q2.pop_front());
    check_eq("d2.B", db2, q2.pop_front());
    $display("txn %0d rst=%0b ce=%0b tk=%0b pre=%0b we=%0b wa=%0d wd=%h ra=%0d rb=%0d cs=%0b | d0=%h/%h d1=%h/%h d2=%h/%h",
             txn, rst, ce, tk, pr, we, wa, wd, ra, rb, c, da0, db0, da1, db1, da2, db2);
    txn++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; ClockEnable = 1'b1; Tick = 1'b1; pre = 1'b0;
    WriteEnable = 1'b0; WriteAddr = '0; WriteData = '0;
    ReadAddrA = '0; ReadAddrB = '0; cs = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 32; i++) m[k][i] = 32'd0;
      out_a[k] = 32'd0;
      out_b[k] = 32'd0;
    end
    @(posedge Clock);
    #1;
    Reset = 1'b0;

    //    rst ce tk pre we wa     wd             ra     rb     cs
    step(0, 1, 1, 0, 0, 5'd0,  32'h0,          5'd5,  5'd31, 0);  // reset state
    step(0, 1, 1, 0, 1, 5'd5,  32'hDEADBEEF,   5'd5,  5'd5,  0);  // write + bypass
    step(0, 1, 1, 0, 0, 5'd0,  32'h0,          5'd5,  5'd5,  0);
    step(0, 1, 1, 0, 1, 5'd0,  32'h12345678,   5'd0,  5'd0,  0);  // write r0
    step(0, 1, 1, 0, 0, 5'd0,  32'h0,          5'd0,  5'd5,  0);
    step(0, 1, 1, 1, 1, 5'd4,  32'h0000_0044,  5'd1,  5'd0,  0);  // preset beats write
    step(0, 1, 1, 0, 0, 5'd0,  32'h0,          5'd31, 5'd4,  0);
    step(0, 1, 1, 0, 0, 5'd0,  32'h0,          5'd23, 5'd24, 0);
    step(0, 1, 1, 0, 1, 5'd30, 32'h0000_0055,  5'd30, 5'd30, 0);  // out of range on d1
    step(0, 1, 1, 0, 0, 5'd0,  32'h0,          5'd30, 5'd23, 0);
    step(0, 1, 1, 0, 1, 5'd7,  32'hA5A5A5A5,   5'd7,  5'd7,  0);  // latency/bypass
    step(0, 1, 1, 0, 0, 5'd0,  32'h0,          5'd7,  5'd7,  0);
    step(0, 1, 0, 1, 1, 5'd9,  32'h0000_0099,  5'd9,  5'd5,  0);  // Tick=0
    step(0, 0, 1, 1, 1, 5'd9,  32'h0000_0099,  5'd9,  5'd5,  0);  // ClockEnable=0
    step(0, 1, 1, 0, 0, 5'd0,  32'h0,          5'd9,  5'd7,  0);
    step(1, 1, 0, 1, 1, 5'd9,  32'h0000_0099,  5'd9,  5'd7,  0);  // reset with Tick=0
    step(0, 1, 1, 0, 0, 5'd0,  32'h0,          5'd5,  5'd7,  0);
    step(0, 1, 1, 0, 0, 5'd0,  32'h0,          5'd31, 5'd1,  0);
    step(0, 1, 1, 0, 1, 5'd3,  32'h0BADF00D,   5'd3,  5'd3,  1);  // cs=1 during write
    step(0, 1, 1, 0, 0, 5'd0,  32'h0,          5'd3,  5'd3,  0);

    for (int n = 0; n < 60; n++) begin
      step(($urandom_range(0, 31) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 31)),
           $urandom,
           5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)),
           ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
